// File: rtl/display_pkg.sv
// Shared types, constants and helpers for the
// seven-segment display scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_ON
  } state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] AN_OFF = 4'b0000;
  localparam logic [3:0] AN_D0  = 4'b0001;
  localparam logic [3:0] AN_D1  = 4'b0010;
  localparam logic [3:0] AN_D2  = 4'b0100;
  localparam logic [3:0] AN_D3  = 4'b1000;

  function automatic int cnt_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

  function automatic logic [3:0] nibble(
    input logic [15:0] v,
    input logic [1:0]  s
  );
    return v[{s, 2'b00} +: 4];
  endfunction

  // Leading zeros are judged from the top nibble down.
  function automatic logic lz_blank(
    input logic [15:0] v,
    input logic [1:0]  s
  );
    logic b;
    b = 1'b0;
    unique case (s)
      2'd3:    b = (v[15:12] == 4'h0);
      2'd2:    b = (v[15:8] == 8'h00);
      2'd1:    b = (v[15:4] == 12'h000);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic [3:0] anode(input logic [1:0] s);
    logic [3:0] a;
    a = AN_OFF;
    unique case (s)
      2'd0:    a = AN_D0;
      2'd1:    a = AN_D1;
      2'd2:    a = AN_D2;
      default: a = AN_D3;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot counter and digit index for the display scan.
// Exposes next-cycle values so the top can register outputs.
import display_pkg::*;

module scan_prescaler #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic       active,
  output logic       slot_end,
  output logic       frame_start,
  output logic       in_blank,
  output logic [1:0] sel_nxt
);

  localparam int CW = cnt_width(SCAN_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    sel;

  // in_blank describes the slot position entered at the next edge.
  always_comb begin
    slot_end    = active && (cnt == CW'(SCAN_DIV - 1));
    frame_start = i_Enable &&
                  (!active ||
                   (slot_end && sel == 2'(NUM_DIGITS - 1)));
    cnt_nxt     = cnt + 1'b1;
    sel_nxt     = sel;
    if (!i_Enable || !active) begin
      cnt_nxt = '0;
      sel_nxt = '0;
    end else if (slot_end) begin
      cnt_nxt = '0;
      sel_nxt = sel + 1'b1;
    end
    in_blank = (cnt_nxt < CW'(BLANK_CYC));
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt <= '0;
      sel <= '0;
    end else begin
      cnt <= cnt_nxt;
      sel <= sel_nxt;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// 4-digit multiplexed seven-segment scan scheduler with
// double-buffered value, dead time and leading-zero blanking.
import display_pkg::*;

module display_scan_controller #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic [15:0] i_Data,
  input  logic        i_Load,
  input  logic        i_Blank_Lz,
  output logic        o_Ready,
  output logic [3:0]  o_Anodo,
  output logic [1:0]  o_Sel,
  output logic [3:0]  o_Digit,
  output logic        o_Frame
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] act_q;
  logic [15:0] act_nxt;
  logic [15:0] stage_q;
  logic        pending;
  logic        slot_end;
  logic        frame_start;
  logic        in_blank;
  logic [1:0]  sel_nxt;
  logic        dark;

  scan_prescaler #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_pre (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Enable    (i_Enable),
    .active      (state != ST_IDLE),
    .slot_end    (slot_end),
    .frame_start (frame_start),
    .in_blank    (in_blank),
    .sel_nxt     (sel_nxt)
  );

  always_comb begin
    state_nxt = state;
    if (!i_Enable) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  state_nxt = ST_BLANK;
        ST_BLANK: if (!in_blank) state_nxt = ST_ON;
        ST_ON:    if (slot_end) state_nxt = ST_BLANK;
        default:  state_nxt = ST_IDLE;
      endcase
    end
    act_nxt = (frame_start && pending) ? stage_q : act_q;
    dark    = i_Blank_Lz && lz_blank(act_nxt, sel_nxt);
  end

  // Outputs are built from next-cycle values so all stay aligned.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state   <= ST_IDLE;
      act_q   <= '0;
      stage_q <= '0;
      pending <= 1'b0;
      o_Ready <= 1'b1;
      o_Anodo <= AN_OFF;
      o_Sel   <= '0;
      o_Digit <= '0;
      o_Frame <= 1'b0;
    end else begin
      state   <= state_nxt;
      act_q   <= act_nxt;
      o_Frame <= frame_start;
      o_Sel   <= sel_nxt;
      o_Digit <= nibble(act_nxt, sel_nxt);
      o_Anodo <= (state_nxt == ST_ON && !dark) ?
                 anode(sel_nxt) : AN_OFF;
      if (frame_start && pending) begin
        pending <= 1'b0;
        o_Ready <= 1'b1;
      end
      if (i_Load && o_Ready) begin
        stage_q <= i_Data;
        pending <= 1'b1;
        o_Ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller
// with SCAN_DIV=8, BLANK_CYC=2.
module tb_display_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] data;
  logic        load;
  logic        blz;
  logic        rdy;
  logic [3:0]  an;
  logic [1:0]  sel;
  logic [3:0]  dig;
  logic        frm;

  int nvec;
  int nerr;

  display_scan_controller #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst_n),
    .i_Enable   (en),
    .i_Data     (data),
    .i_Load     (load),
    .i_Blank_Lz (blz),
    .o_Ready    (rdy),
    .o_Anodo    (an),
    .o_Sel      (sel),
    .o_Digit    (dig),
    .o_Frame    (frm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input int unsigned got,
    input int unsigned want
  );
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frm) seen = 1'b1;
    end
    check("frame_timeout", seen, 1);
  endtask

  // Entered on the negedge of a frame's first cycle.
  task automatic scan_frame(
    input logic [15:0] v,
    input logic [3:0]  lit,
    input logic        r
  );
    int          s;
    int          k;
    logic [3:0]  ea;
    logic [3:0]  ed;
    for (int c = 0; c < 32; c++) begin
      s  = c / 8;
      k  = c % 8;
      ea = (k >= 2 && lit[s]) ? (4'b0001 << s) : 4'b0000;
      ed = v[s*4 +: 4];
      check($sformatf("an c%0d", c), an, ea);
      check($sformatf("sel c%0d", c), sel, s);
      check($sformatf("dig c%0d", c), dig, ed);
      check($sformatf("frm c%0d", c), frm, (c == 0));
      check($sformatf("rdy c%0d", c), rdy, r);
      @(negedge clk);
    end
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    data  = '0;
    load  = 1'b0;
    blz   = 1'b0;
    #12;
    check("rst_an", an, 0);
    check("rst_sel", sel, 0);
    check("rst_dig", dig, 0);
    check("rst_frm", frm, 0);
    check("rst_rdy", rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // basic scan of 1234
    data = 16'h1234;
    load = 1'b1;
    step(1);
    load = 1'b0;
    check("ld_rdy0", rdy, 0);
    en = 1'b1;
    wait_frame();
    scan_frame(16'h1234, 4'hF, 1'b1);
    scan_frame(16'h1234, 4'hF, 1'b1);

    // handshake; second load must be dropped
    step(5);
    data = 16'hABCD;
    load = 1'b1;
    step(1);
    check("hs_rdy0", rdy, 0);
    data = 16'h5555;
    step(1);
    load = 1'b0;
    check("hs_rdy_hold", rdy, 0);
    wait_frame();
    scan_frame(16'hABCD, 4'hF, 1'b1);
    scan_frame(16'hABCD, 4'hF, 1'b1);

    // leading-zero blanking
    data = 16'h0050;
    load = 1'b1;
    blz  = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame();
    scan_frame(16'h0050, 4'b0011, 1'b1);
    blz = 1'b0;
    scan_frame(16'h0050, 4'hF, 1'b1);
    data = 16'h0000;
    load = 1'b1;
    blz  = 1'b1;
    step(1);
    load = 1'b0;
    wait_frame();
    scan_frame(16'h0000, 4'b0001, 1'b1);

    // disable at slot 2, cnt 5
    blz = 1'b0;
    step(21);
    check("dis_pre_sel", sel, 2);
    check("dis_pre_an", an, 4'b0100);
    en = 1'b0;
    step(1);
    check("dis_an", an, 0);
    check("dis_sel", sel, 0);
    check("dis_frm", frm, 0);
    step(2);
    check("idle_an", an, 0);
    en = 1'b1;
    step(1);
    scan_frame(16'h0000, 4'hF, 1'b1);

    // load on the frame-start edge waits a frame
    step(31);
    data = 16'h9876;
    load = 1'b1;
    step(1);
    load = 1'b0;
    scan_frame(16'h0000, 4'hF, 1'b0);
    scan_frame(16'h9876, 4'hF, 1'b1);

    // async reset during a lit cycle
    step(11);
    check("pre_rst_an", an, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an", an, 0);
    check("arst_sel", sel, 0);
    check("arst_rdy", rdy, 1);
    check("arst_frm", frm, 0);
    check("arst_dig", dig, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Scheduler for the 4-digit multiplexed seven-segment display.
- Sequences anode selection and the digit index, with a programmable dead time between digits to suppress ghosting.
- Double-buffers the 16-bit display value, with a ready/load handshake; updates take effect only at frame boundaries.
- Applies optional leading-zero blanking.
- o_Digit feeds the downstream hex-to-segment decoder.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (including blank time); SCAN_DIV ≥ 2
BLANK_CYC, 500, dead-time cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYC < SCAN_DIV

Ports:
i_Clk  in  1  system clock; all state on rising edge
i_Rst  in  1  asynchronous, active-low reset
i_Enable  in  1  1 = scan running; 0 = display dark, scan held at slot 0
i_Data  in  16  display value; nibble k drives digit k (k=0 rightmost)
i_Load  in  1  load request; accepted only when o_Ready=1
i_Blank_Lz  in  1  leading-zero blanking enable
o_Ready  out  1  staging register free; a load will be accepted
o_Anodo  out  4  one-hot active-high anode enable, 0000 = all off
o_Sel  out  2  current digit index 0..3
o_Digit  out  4  nibble of active register for current digit
o_Frame  out  1  one-cycle pulse marking the first cycle of slot 0

Behaviour:
- Reset (i_Rst=0, async):
  - o_Anodo=0000, o_Sel=00, o_Digit=0, o_Frame=0, o_Ready=1.
  - Active and staging registers cleared; pending flag cleared.
  - Slot counter cnt=0; state IDLE.
- All outputs are registered and mutually consistent in every cycle.
- States: IDLE, BLANK, ON.
  - IDLE:
    - o_Anodo=0000, o_Sel=00, cnt=0.
    - If i_Enable=1: next edge enters BLANK with sel=0, cnt=0, and performs a frame start.
  - BLANK:
    - cnt < BLANK_CYC; o_Anodo=0000; o_Sel and o_Digit already show the new digit.
    - Transition to ON when cnt increments to BLANK_CYC.
  - ON:
    - BLANK_CYC ≤ cnt ≤ SCAN_DIV-1.
    - o_Anodo = 1<<sel, unless the digit is blanked, in which case o_Anodo=0000.
    - At cnt=SCAN_DIV-1: cnt<=0, sel<=sel+1 mod 4, state BLANK.
    - The wrap from sel 3 to 0 is a frame start.
  - From any non-IDLE state, i_Enable=0 gives IDLE at the next edge. Pending data and o_Ready are preserved.
- Frame start edge:
  - o_Frame<=1 for exactly one cycle.
  - If pending was set before this edge: active<=staging, pending<=0, o_Ready<=1.
  - Frame period = 4*SCAN_DIV cycles.
- Load handshake:
  - On an edge where i_Load=1 and o_Ready=1: staging<=i_Data, pending<=1, o_Ready<=0.
  - i_Load while o_Ready=0 is ignored; staging is unchanged.
  - A load accepted on a frame-start edge is not transferred on that edge. It waits for the next frame start.
- Leading-zero blanking (i_Blank_Lz=1), evaluated on the active register:
  - Digit 3 is blanked if nibble3=0.
  - Digit 2 is blanked if nibbles 3..2 = 0.
  - Digit 1 is blanked if nibbles 3..1 = 0.
  - Digit 0 is never blanked.
  - i_Blank_Lz is sampled continuously.
- Reset asserted mid-slot: outputs go to their reset values immediately, without waiting for a clock edge.

Decomposition:
- Package display_pkg holds:
  - state enum (ST_IDLE, ST_BLANK, ST_ON);
  - NUM_DIGITS=4;
  - one-hot anode constants AN_D0..AN_D3 and AN_OFF=4'b0000;
  - a function for the slot counter width, clog2(SCAN_DIV).
- One sub-module: scan_prescaler.
  - Slot counter cnt and digit index sel.
  - Outputs: slot_end, frame_start, in_blank.
  - Parameterised by SCAN_DIV and BLANK_CYC.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYC=2.
1. Reset: pulse i_Rst=0 during an ON cycle -> o_Anodo=0000, o_Sel=00, o_Ready=1 before the next clock edge.
2. Basic scan: enable, load 16'h1234, wait for one o_Frame -> per slot, cycles 0-1 have o_Anodo=0000 and cycles 2-7 are lit:
   - slot 0: anode 0001, o_Digit=4;
   - slot 1: anode 0010, o_Digit=3;
   - slot 2: anode 0100, o_Digit=2;
   - slot 3: anode 1000, o_Digit=1;
   - o_Frame repeats every 32 cycles.
3. Handshake: i_Load with 16'hABCD mid-frame -> o_Ready=0 from the next cycle; i_Load with 16'h5555 while o_Ready=0 is ignored; in the next o_Frame cycle o_Ready=1, and slot 0 shows D, slot 1 C, slot 2 B, slot 3 A.
4. Leading-zero blanking: active value 16'h0050 with i_Blank_Lz=1 -> digits 3 and 2 never lit, digit 1 shows 5, digit 0 shows 0. With i_Blank_Lz=0 all four digits lit. With 16'h0000 only digit 0 lit.
5. Disable mid-slot: i_Enable=0 at slot 2, cnt=5 -> next cycle o_Anodo=0000, o_Sel=00. Re-enable -> o_Frame=1 on the following edge and slot 0 restarts with cnt=0.
6. Load on a frame-start edge: i_Load asserted on the same edge as an o_Frame -> active register unchanged and o_Ready=0 for 32 cycles; transfer occurs at the next o_Frame.
